rggen_lock_key_sequencer: RTL and testbench
===========================================

Name: rggen_lock_key_sequencer

Overview:
- Generates the lock/enable control consumed by RWL/RWE bit fields in the rggen register blocks.
- A two-step magic-key write sequence to a key register opens a write window; any further key write closes it.
- Repeated wrong sequences can freeze the lock until reset.
- Sits between the key-register decode of the register block and the i_lock_or_enable inputs of protected fields.

Parameters:
- KEY_WIDTH, 32, width of key register data
- KEY0, 32'h0000_A5A5, first key value (lower KEY_WIDTH bits used)
- KEY1, 32'h0000_5A5A, second key value
- MAX_FAIL, 3, wrong sequences before FROZEN; 0 disables freezing
- TIMEOUT, 1024, cycles before an open window or half-entered sequence auto-closes (used only with the optional feature); must be >= 2

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_key_write  input  1  single-cycle strobe: write access to key register
- i_key_data  input  KEY_WIDTH  write data
- i_key_mask  input  KEY_WIDTH  byte/bit write mask
- o_lock  output  1  1 = protected fields locked; drives RWL fields in LOCK mode
- o_enable  output  1  always ~o_lock; drives RWE fields in ENABLE mode
- o_frozen  output  1  1 = FROZEN, unlock impossible until reset
- o_fail_count  output  $clog2(MAX_FAIL+1) (min 1)  wrong sequences since last successful unlock
- o_state  output  2  encoded FSM state, for status readback

Behaviour:
- Reset values: state LOCKED, o_lock=1, o_enable=0, o_frozen=0, o_fail_count=0.
- Reset is asynchronous and may assert in any state; the FSM returns to LOCKED immediately.
- Valid key write: i_key_write=1 and i_key_mask all ones. A partial-mask write is a wrong key.
- Match compares the full i_key_data against KEY0/KEY1 truncated to KEY_WIDTH.
- All outputs are registered. o_lock changes in the cycle after the strobe cycle; no combinational path from inputs to outputs.
- FSM states: LOCKED=2'd0, KEY0_OK=2'd1, UNLOCKED=2'd2, FROZEN=2'd3.
- LOCKED:
  - valid KEY0 -> KEY0_OK
  - any other write -> fail
- KEY0_OK:
  - valid KEY1 -> UNLOCKED; fail count cleared
  - valid KEY0 -> stays KEY0_OK, no fail
  - other write -> fail
- UNLOCKED: any key write, of any value -> LOCKED, no fail.
- FROZEN: ignores all writes until reset.
- Fail event:
  - If MAX_FAIL!=0 and the count reaches MAX_FAIL -> FROZEN.
  - Otherwise -> LOCKED.
  - The counter saturates at MAX_FAIL.
- o_lock=0 only in UNLOCKED. o_frozen=1 only in FROZEN.
- A write strobe is honoured every cycle; back-to-back strobes are each evaluated against the state updated by the previous one.
- If KEY0==KEY1, KEY0_OK + KEY0 write takes the KEY1 (unlock) path.

Optional Feature:
- Macro RGGEN_LOCK_TIMEOUT_EN.
- Defined:
  - A timer counts cycles spent in KEY0_OK or UNLOCKED.
  - It restarts on every state change, including KEY0_OK re-entry via KEY0.
  - After TIMEOUT cycles in the state, the FSM goes to LOCKED with no fail increment.
  - A key write in the expiring cycle takes priority over the timeout.
- Undefined: no timer logic; windows stay open indefinitely; TIMEOUT is ignored.

Decomposition:
- The shared package rggen_rtl_type_pkg holds:
  - enum rggen_lock_state_e (LOCKED/KEY0_OK/UNLOCKED/FROZEN, 2-bit)
  - the existing rggen_rwle_mode
- One sub-module, rggen_lock_timer:
  - parameter TIMEOUT
  - inputs i_restart, i_run
  - output o_expired
  - instantiated only under RGGEN_LOCK_TIMEOUT_EN

Test Plan:
- Reset, then write A5A5 and 5A5A with full mask -> o_lock=1 after the first write, o_lock=0 one cycle after the second; o_state=2.
- UNLOCKED, write 0x1234 -> o_lock=1 next cycle; o_fail_count unchanged (0).
- Three wrong sequences from LOCKED (0x1, 0x2, then A5A5 followed by 0xFFFF) -> o_fail_count 1,2,3; o_frozen=1; a subsequent A5A5/5A5A leaves o_lock=1. rst_n pulse -> all outputs return to reset values.
- A5A5 with i_key_mask=0x0000FFFF -> treated as wrong; o_fail_count=1, state LOCKED.
- Back-to-back strobes A5A5, A5A5, 5A5A on consecutive cycles -> unlocked in the cycle after the third, no fail.
- With RGGEN_LOCK_TIMEOUT_EN, TIMEOUT=8, unlock then idle -> o_lock returns to 1 exactly 8 cycles after entering UNLOCKED. A key write on the 8th cycle relocks via the write path; o_fail_count stays 0.

Source files
------------

// File: rtl/rggen_rtl_type_pkg.sv
// rtl/rggen_rtl_type_pkg.sv - shared rggen types for lock/enable control
package rggen_rtl_type_pkg;

   typedef enum logic {
      RGGEN_LOCK_MODE,
      RGGEN_ENABLE_MODE
   } rggen_rwle_mode;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      KEY0_OK  = 2'd1,
      UNLOCKED = 2'd2,
      FROZEN   = 2'd3
   } rggen_lock_state_e;

   // Width of the fail counter; a disabled limit (0) still needs one bit.
   function automatic int lock_fail_count_width(int max_fail);
      return (max_fail > 0) ? $clog2(max_fail + 1) : 1;
   endfunction

endpackage

// File: rtl/rggen_lock_timer.sv
// rtl/rggen_lock_timer.sv - dwell timer closing open lock windows after TIMEOUT cycles
module rggen_lock_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   input  logic i_run,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (i_restart || !i_run) begin
         count <= '0;
      end else if (count != LAST) begin
         count <= count + CNT_W'(1);
      end
   end

   // Count holds the number of completed cycles in the state; the last one closes it.
   assign o_expired = i_run && (count == LAST);

endmodule

// File: rtl/rggen_lock_key_sequencer.sv
// rtl/rggen_lock_key_sequencer.sv - two-key lock/enable sequencer; RGGEN_LOCK_TIMEOUT_EN adds window timeout
module rggen_lock_key_sequencer
   import rggen_rtl_type_pkg::*;
#(
   parameter int                   KEY_WIDTH = 32,
   parameter logic [KEY_WIDTH-1:0] KEY0      = 32'h0000_A5A5,
   parameter logic [KEY_WIDTH-1:0] KEY1      = 32'h0000_5A5A,
   parameter int                   MAX_FAIL  = 3,
   parameter int                   TIMEOUT   = 1024
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      i_key_write,
   input  logic [KEY_WIDTH-1:0]                      i_key_data,
   input  logic [KEY_WIDTH-1:0]                      i_key_mask,
   output logic                                      o_lock,
   output logic                                      o_enable,
   output logic                                      o_frozen,
   output logic [lock_fail_count_width(MAX_FAIL)-1:0] o_fail_count,
   output logic [1:0]                                o_state
);

   localparam int FAIL_W = lock_fail_count_width(MAX_FAIL);
   localparam logic [FAIL_W-1:0] FAIL_SAT = FAIL_W'(MAX_FAIL);

   rggen_lock_state_e state;
   rggen_lock_state_e nxt_state;
   logic [FAIL_W-1:0] nxt_fail;
   logic [FAIL_W-1:0] fail_inc;
   logic              fail_evt;
   logic              valid_write;
   logic              is_key0;
   logic              is_key1;
   logic              expired;

   assign valid_write = i_key_write && (i_key_mask == '1);
   assign is_key0     = valid_write && (i_key_data == KEY0);
   assign is_key1     = valid_write && (i_key_data == KEY1);
   assign fail_inc    = (o_fail_count == FAIL_SAT) ? o_fail_count : o_fail_count + FAIL_W'(1);

`ifdef RGGEN_LOCK_TIMEOUT_EN
   rggen_lock_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (i_key_write && (state != FROZEN)),
      .i_run     ((state == KEY0_OK) || (state == UNLOCKED)),
      .o_expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT < 2);
   assign expired        = 1'b0;
`endif

   always_comb begin
      nxt_state = state;
      nxt_fail  = o_fail_count;
      fail_evt  = 1'b0;
      case (state)
         LOCKED: begin
            if (is_key0)          nxt_state = KEY0_OK;
            else if (i_key_write) fail_evt  = 1'b1;
         end
         KEY0_OK: begin
            // KEY1 is checked first so identical keys take the unlock path.
            if (is_key1) begin
               nxt_state = UNLOCKED;
               nxt_fail  = '0;
            end else if (is_key0) begin
               nxt_state = KEY0_OK;
            end else if (i_key_write) begin
               fail_evt  = 1'b1;
            end else if (expired) begin
               nxt_state = LOCKED;
            end
         end
         UNLOCKED: begin
            if (i_key_write || expired) nxt_state = LOCKED;
         end
         default: nxt_state = FROZEN;
      endcase
      if (fail_evt) begin
         nxt_fail  = fail_inc;
         nxt_state = ((MAX_FAIL != 0) && (fail_inc == FAIL_SAT)) ? FROZEN : LOCKED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOCKED;
         o_lock       <= 1'b1;
         o_enable     <= 1'b0;
         o_frozen     <= 1'b0;
         o_fail_count <= '0;
      end else begin
         state        <= nxt_state;
         o_lock       <= (nxt_state != UNLOCKED);
         o_enable     <= (nxt_state == UNLOCKED);
         o_frozen     <= (nxt_state == FROZEN);
         o_fail_count <= nxt_fail;
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_rggen_lock_key_sequencer.sv
// tb/tb_rggen_lock_key_sequencer.sv - vector bench for rggen_lock_key_sequencer (RGGEN_LOCK_TIMEOUT_EN adds timeout checks)
module tb_rggen_lock_key_sequencer;

   localparam logic [31:0] ONES = 32'hFFFF_FFFF;
   localparam logic [1:0]  S_L = 2'd0, S_K = 2'd1, S_U = 2'd2, S_F = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_write = 1'b0;
   logic [31:0] key_data = '0;
   logic [31:0] key_mask = '0;
   logic        lock, enable, frozen;
   logic [1:0]  fail_count;
   logic [1:0]  state;

   int n_vec = 0;
   int n_fail = 0;

   rggen_lock_key_sequencer #(
      .KEY_WIDTH (32),
      .KEY0      (32'h0000_A5A5),
      .KEY1      (32'h0000_5A5A),
      .MAX_FAIL  (3),
      .TIMEOUT   (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_key_write  (key_write),
      .i_key_data   (key_data),
      .i_key_mask   (key_mask),
      .o_lock       (lock),
      .o_enable     (enable),
      .o_frozen     (frozen),
      .o_fail_count (fail_count),
      .o_state      (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        wr;
      logic [31:0] data;
      logic [31:0] mask;
      logic [1:0]  exp_state;
      logic        exp_lock;
      logic        exp_frozen;
      logic [1:0]  exp_fail;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [1:0] st, input logic lk,
                        input logic fz, input logic [1:0] fc);
      n_vec++;
      if (state !== st || lock !== lk || enable !== ~lk || frozen !== fz || fail_count !== fc) begin
         n_fail++;
         $display("FAIL %s: got state=%0d lock=%b enable=%b frozen=%b fail=%0d, want state=%0d lock=%b enable=%b frozen=%b fail=%0d",
                  name, state, lock, enable, frozen, fail_count, st, lk, ~lk, fz, fc);
      end
   endtask

   task automatic step(input logic rst, input logic wr, input logic [31:0] d, input logic [31:0] m);
      @(negedge clk);
      rst_n     = ~rst;
      key_write = wr;
      key_data  = d;
      key_mask  = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"reset",          1'b1, 1'b0, 32'h0,      ONES,         S_L, 1'b1, 1'b0, 2'd0};
      vecs[1]  = '{"idle",           1'b0, 1'b0, 32'h0,      ONES,         S_L, 1'b1, 1'b0, 2'd0};
      vecs[2]  = '{"key0",           1'b0, 1'b1, 32'hA5A5,   ONES,         S_K, 1'b1, 1'b0, 2'd0};
      vecs[3]  = '{"key1_unlock",    1'b0, 1'b1, 32'h5A5A,   ONES,         S_U, 1'b0, 1'b0, 2'd0};
      vecs[4]  = '{"unlocked_hold",  1'b0, 1'b0, 32'h0,      ONES,         S_U, 1'b0, 1'b0, 2'd0};
      vecs[5]  = '{"relock_1234",    1'b0, 1'b1, 32'h1234,   ONES,         S_L, 1'b1, 1'b0, 2'd0};
      vecs[6]  = '{"wrong_1",        1'b0, 1'b1, 32'h1,      ONES,         S_L, 1'b1, 1'b0, 2'd1};
      vecs[7]  = '{"wrong_2",        1'b0, 1'b1, 32'h2,      ONES,         S_L, 1'b1, 1'b0, 2'd2};
      vecs[8]  = '{"key0_again",     1'b0, 1'b1, 32'hA5A5,   ONES,         S_K, 1'b1, 1'b0, 2'd2};
      vecs[9]  = '{"wrong_3_freeze", 1'b0, 1'b1, 32'hFFFF,   ONES,         S_F, 1'b1, 1'b1, 2'd3};
      vecs[10] = '{"frozen_key0",    1'b0, 1'b1, 32'hA5A5,   ONES,         S_F, 1'b1, 1'b1, 2'd3};
      vecs[11] = '{"frozen_key1",    1'b0, 1'b1, 32'h5A5A,   ONES,         S_F, 1'b1, 1'b1, 2'd3};
      vecs[12] = '{"reset_frozen",   1'b1, 1'b0, 32'h0,      ONES,         S_L, 1'b1, 1'b0, 2'd0};
      vecs[13] = '{"partial_mask",   1'b0, 1'b1, 32'hA5A5,   32'h0000FFFF, S_L, 1'b1, 1'b0, 2'd1};
      vecs[14] = '{"b2b_key0_a",     1'b0, 1'b1, 32'hA5A5,   ONES,         S_K, 1'b1, 1'b0, 2'd1};
      vecs[15] = '{"b2b_key0_b",     1'b0, 1'b1, 32'hA5A5,   ONES,         S_K, 1'b1, 1'b0, 2'd1};
      vecs[16] = '{"b2b_key1",       1'b0, 1'b1, 32'h5A5A,   ONES,         S_U, 1'b0, 1'b0, 2'd0};
      vecs[17] = '{"unlocked_key0",  1'b0, 1'b1, 32'hA5A5,   ONES,         S_L, 1'b1, 1'b0, 2'd0};
      vecs[18] = '{"locked_key1",    1'b0, 1'b1, 32'h5A5A,   ONES,         S_L, 1'b1, 1'b0, 2'd1};
      vecs[19] = '{"key0_retry",     1'b0, 1'b1, 32'hA5A5,   ONES,         S_K, 1'b1, 1'b0, 2'd1};
      vecs[20] = '{"key1_partial",   1'b0, 1'b1, 32'h5A5A,   32'hFFFFFFFE, S_L, 1'b1, 1'b0, 2'd2};
      vecs[21] = '{"reset_end",      1'b1, 1'b0, 32'h0,      ONES,         S_L, 1'b1, 1'b0, 2'd0};

      for (int i = 0; i < 22; i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].mask);
         check(vecs[i].name, vecs[i].exp_state, vecs[i].exp_lock, vecs[i].exp_frozen, vecs[i].exp_fail);
      end

      // Asynchronous reset while unlocked, observed before any clock edge.
      step(1'b0, 1'b1, 32'hA5A5, ONES);
      step(1'b0, 1'b1, 32'h5A5A, ONES);
      check("pre_async_rst", S_U, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      key_write = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_rst", S_L, 1'b1, 1'b0, 2'd0);
      step(1'b0, 1'b0, 32'h0, ONES);

`ifdef RGGEN_LOCK_TIMEOUT_EN
      step(1'b0, 1'b1, 32'hA5A5, ONES);
      step(1'b0, 1'b1, 32'h5A5A, ONES);
      check("tmo_enter", S_U, 1'b0, 1'b0, 2'd0);
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b0, 32'h0, ONES);
         check("tmo_hold", S_U, 1'b0, 1'b0, 2'd0);
      end
      step(1'b0, 1'b0, 32'h0, ONES);
      check("tmo_expire", S_L, 1'b1, 1'b0, 2'd0);

      step(1'b0, 1'b1, 32'hA5A5, ONES);
      step(1'b0, 1'b1, 32'h5A5A, ONES);
      for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 32'h0, ONES);
      check("tmo_last_cycle", S_U, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 32'h1234, ONES);
      check("tmo_write_relock", S_L, 1'b1, 1'b0, 2'd0);

      step(1'b0, 1'b1, 32'hA5A5, ONES);
      for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 32'h0, ONES);
      step(1'b0, 1'b1, 32'h5A5A, ONES);
      check("tmo_key1_priority", S_U, 1'b0, 1'b0, 2'd0);

      step(1'b0, 1'b1, 32'h1234, ONES);
      step(1'b0, 1'b1, 32'hA5A5, ONES);
      step(1'b0, 1'b1, 32'hA5A5, ONES);
      for (int k = 1; k < 8; k++) step(1'b0, 1'b0, 32'h0, ONES);
      check("tmo_key0_reenter_hold", S_K, 1'b1, 1'b0, 2'd0);
      step(1'b0, 1'b0, 32'h0, ONES);
      check("tmo_key0_expire", S_L, 1'b1, 1'b0, 2'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
